// File: rtl/uart_rx_deser.sv
// uart_rx_deser: oversampling UART receive deserializer.
// Synchronizes the RX pin, finds the start edge and samples each bit at its
// centre on a programmable tick. Data is delivered through a one-entry
// holding register with valid/ready handshake. Framing, parity and overrun
// problems are reported as one-cycle pulses.
module uart_rx_deser #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 RX,
    input  logic [15:0]          BAUD_DIV,
    input  logic                 PARITY_EN,
    input  logic                 PARITY_ODD,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);

    localparam int SW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Sample index of the start-bit centre and of a full bit period.
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Line synchronizer and edge history.
    logic rx_meta_q, rx_meta_d;
    logic rx_s_q,    rx_s_d;
    logic rx_prev_q, rx_prev_d;

    // Receive FSM and its counters.
    state_t               state_q,    state_d;
    logic [15:0]          tick_cnt_q, tick_cnt_d;
    logic [15:0]          div_m1_q,   div_m1_d;
    logic                 par_en_q,   par_en_d;
    logic                 par_odd_q,  par_odd_d;
    logic [SW-1:0]        samp_cnt_q, samp_cnt_d;
    logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 par_bad_q,  par_bad_d;

    // Holding register and status pulses.
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q,    overrun_d;

    // Decoded events shared by the FSM and the output stage.
    logic fall_edge;
    logic tick;
    logic mid_done;
    logic bit_done;
    logic parity_exp;
    logic stop_sample;
    logic good_byte;
    logic accept;

    assign fall_edge   = rx_prev_q & ~rx_s_q;
    assign tick        = (tick_cnt_q == div_m1_q);
    assign mid_done    = tick & (samp_cnt_q == SAMP_MID);
    assign bit_done    = tick & (samp_cnt_q == SAMP_LAST);
    assign parity_exp  = (^shift_q) ^ par_odd_q;
    assign stop_sample = (state_q == S_STOP) & bit_done;
    assign good_byte   = stop_sample & rx_s_q & ~par_bad_q;
    assign accept      = rx_valid_q & RX_READY;

    // Two-flop synchronizer plus one flop of history for edge detection.
    always_comb begin
        rx_meta_d = RX;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
    end

    // Next-state logic for the bit-timing FSM, its counters and shift register.
    // NOTE: every signal gets a default at the top so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        div_m1_d   = div_m1_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;

        // The tick counter free-runs only while a frame is in progress.
        if (state_q == S_IDLE) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 16'd1;
        end

        if (tick && (state_q != S_IDLE)) begin
            samp_cnt_d = samp_cnt_q + SW'(1);
        end else begin
            samp_cnt_d = samp_cnt_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (fall_edge) begin
                    state_d    = S_START;
                    samp_cnt_d = '0;
                    bit_cnt_d  = '0;
                    par_bad_d  = 1'b0;
                    // Line settings are frozen for the whole frame.
                    div_m1_d   = (BAUD_DIV == 16'd0) ? 16'd0 : BAUD_DIV - 16'd1;
                    par_en_d   = PARITY_EN;
                    par_odd_d  = PARITY_ODD;
                end
            end

            S_START: begin
                if (mid_done) begin
                    samp_cnt_d = '0;
                    // A line that is high again at mid-bit was only a glitch.
                    state_d    = rx_s_q ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (bit_done) begin
                    samp_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end

            S_PARITY: begin
                if (bit_done) begin
                    samp_cnt_d = '0;
                    par_bad_d  = (rx_s_q != parity_exp);
                    state_d    = S_STOP;
                end
            end

            S_STOP: begin
                // Leave at the stop-bit centre so a following start edge is not missed.
                if (bit_done) begin
                    samp_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d    = S_IDLE;
                samp_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // Stop-bit outcome, holding register handshake and error pulses.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = stop_sample & ~rx_s_q;
        parity_err_d = stop_sample & rx_s_q & par_bad_q;
        overrun_d    = 1'b0;

        if (good_byte) begin
            if (!rx_valid_q || RX_READY) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                // Unread byte wins; the newcomer is lost.
                overrun_d  = 1'b1;
            end
        end else if (accept) begin
            rx_valid_d = 1'b0;
        end
    end

    // All state registers, with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            div_m1_q     <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            samp_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            div_m1_q     <= div_m1_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign RX_DATA    = rx_data_q;
    assign RX_VALID   = rx_valid_q;
    assign FRAME_ERR  = frame_err_q;
    assign PARITY_ERR = parity_err_q;
    assign OVERRUN    = overrun_q;
    assign BUSY       = (state_q != S_IDLE);

    // Output invariants: a frame reports at most one error, an unread byte
    // stays put, and an overrun implies the holding register was occupied.
    a_one_error : assert property (@(posedge PCLK) disable iff (PRESET)
        !(FRAME_ERR && PARITY_ERR));
    a_data_hold : assert property (@(posedge PCLK) disable iff (PRESET)
        (RX_VALID && !RX_READY) |=> $stable(RX_DATA));
    a_ovr_valid : assert property (@(posedge PCLK) disable iff (PRESET)
        OVERRUN |-> RX_VALID);

endmodule
